// File: rtl/wb_reg_file.sv
// MIPS write-back stage: selects load/ALU value and commits it to a 32x32 register file with two bypassed read ports.
// Writes commit on the rising clock edge; reads are combinational with same-cycle write bypass. No backpressure.
module wb_reg_file (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] readData,
  input  logic [31:0] aluResult,
  input  logic [4:0]  muxInst,
  input  logic [1:0]  WB,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] writeData,
  output logic [31:0] writeCount
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] write_count_q;
  logic [31:0] write_count_d;
  logic [31:0] write_dat;
  logic        write_vld;

  always_comb begin
    write_dat = WB[0] ? readData : aluResult;
    write_vld = WB[1] && (muxInst != 5'd0);
  end

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (write_vld) begin
      regs_d[muxInst] = write_dat;
      write_count_d   = write_count_q + 32'd1;
    end
    // r0 is never stored; keeping it at zero lets synthesis drop the row
    regs_d[0] = 32'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
      write_count_q <= 32'd0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  // The bypass hands the ID stage the value being committed this cycle
  always_comb begin
    if (readReg1 == 5'd0) begin
      readData1 = 32'd0;
    end else if (write_vld && (muxInst == readReg1)) begin
      readData1 = write_dat;
    end else begin
      readData1 = regs_q[readReg1];
    end

    if (readReg2 == 5'd0) begin
      readData2 = 32'd0;
    end else if (write_vld && (muxInst == readReg2)) begin
      readData2 = write_dat;
    end else begin
      readData2 = regs_q[readReg2];
    end
  end

  assign writeData  = write_dat;
  assign writeCount = write_count_q;

endmodule
